// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants and FSM encoding shared by the multicycle ALU.
// Defining ALU_MUL_EN adds the MUL state used by the shift-add multiplier.
package alu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [OP_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [OP_W-1:0] ALU_AND  = 4'd2;
  localparam logic [OP_W-1:0] ALU_XOR  = 4'd3;
  localparam logic [OP_W-1:0] ALU_OR   = 4'd4;
  localparam logic [OP_W-1:0] ALU_SLL  = 4'd5;
  localparam logic [OP_W-1:0] ALU_SRL  = 4'd6;
  localparam logic [OP_W-1:0] ALU_SLT  = 4'd7;
  localparam logic [OP_W-1:0] ALU_SLTU = 4'd8;
  localparam logic [OP_W-1:0] ALU_SRA  = 4'd9;
  localparam logic [OP_W-1:0] ALU_MUL  = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
`ifdef ALU_MUL_EN
    ST_MUL   = 2'd2,
`endif
    ST_SHIFT = 2'd1
  } state_t;

  function automatic logic is_shift_op(
    input logic [OP_W-1:0] op
  );
    return (op == ALU_SLL) ||
           (op == ALU_SRL) ||
           (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_core_comb.sv
// alu_core_comb: combinational add/sub/logic/compare slice with carry and
// signed overflow. Ports: a, b operands; op opcode; res, cout, ovf outputs.
module alu_core_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] res,
  output logic             cout,
  output logic             ovf
);

  logic             sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             lt_s;
  logic             lt_u;

  // subtraction is a + ~b + 1, so carry out means "no borrow"
  assign sub   = (op == ALU_SUB);
  assign b_eff = sub ? ~b : b;
  assign sum   = {1'b0, a} + {1'b0, b_eff}
               + {{WIDTH{1'b0}}, sub};
  assign lt_s  = $signed(a) < $signed(b);
  assign lt_u  = a < b;

  always_comb begin
    res  = '0;
    cout = 1'b0;
    ovf  = 1'b0;
    unique case (op)
      ALU_ADD, ALU_SUB: begin
        res  = sum[WIDTH-1:0];
        cout = sum[WIDTH];
        ovf  = (a[WIDTH-1] == b_eff[WIDTH-1])
            && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND:  res = a & b;
      ALU_XOR:  res = a ^ b;
      ALU_OR:   res = a | b;
      ALU_SLT:  res = {{(WIDTH-1){1'b0}}, lt_s};
      ALU_SLTU: res = {{(WIDTH-1){1'b0}}, lt_u};
      default:  res = '0;
    endcase
  end

endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: registered ALU with valid/ready handshake, iterative
// shifts (SHIFT_STEP bits/cycle) and, with ALU_MUL_EN defined, an unsigned
// shift-add multiplier (opcode 10). Ports: clk, rst_n (sync, active-low),
// in_valid/in_ready, operand_a, operand_b, control, out_valid/out_ready,
// result, carryout, overflow, zero.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [3:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] STEP = SHW'(SHIFT_STEP);

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] core_res;
  logic             core_cout;
  logic             core_ovf;

  alu_core_comb #(
    .WIDTH (WIDTH)
  ) u_core (
    .a    (operand_a),
    .b    (operand_b),
    .op   (control),
    .res  (core_res),
    .cout (core_cout),
    .ovf  (core_ovf)
  );

  function automatic logic [WIDTH-1:0] shift_by(
    input logic [OP_W-1:0]  op,
    input logic [WIDTH-1:0] v,
    input logic [SHW-1:0]   n
  );
    logic [WIDTH-1:0] r;
    unique case (op)
      ALU_SRL: r = v >> n;
      ALU_SRA: r = $signed(v) >>> n;
      default: r = v << n;
    endcase
    return r;
  endfunction

  logic accept;
  logic is_shift;
  logic [SHW-1:0] shamt;
  logic [SHW-1:0] first_amt;
  logic [WIDTH-1:0] first_out;

  assign in_ready  = (state == ST_IDLE)
                  && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign is_shift  = is_shift_op(control);
  assign shamt     = operand_b[SHW-1:0];
  // the accept edge already performs the first shift iteration
  assign first_amt = (shamt > STEP) ? STEP : shamt;
  assign first_out = shift_by(control, operand_a, first_amt);

  logic [WIDTH-1:0] sh_val;
  logic [WIDTH-1:0] sh_val_nxt;
  logic [SHW-1:0]   sh_rem;
  logic [SHW-1:0]   sh_rem_nxt;
  logic [OP_W-1:0]  sh_op;
  logic [OP_W-1:0]  sh_op_nxt;
  logic [SHW-1:0]   sh_amt;
  logic [WIDTH-1:0] sh_out;

  assign sh_amt = (sh_rem > STEP) ? STEP : sh_rem;
  assign sh_out = shift_by(sh_op, sh_val, sh_amt);

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] mul_p;
  logic [2*WIDTH-1:0] mul_p_nxt;
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_a_nxt;
  logic [SHW-1:0]     mul_cnt;
  logic [SHW-1:0]     mul_cnt_nxt;
  logic [2*WIDTH-1:0] mul_first;
  logic [2*WIDTH-1:0] mul_step_p;

  // one shift-add step: add multiplicand into the high half when the
  // current multiplier bit (p[0]) is set, then shift right with carry
  function automatic logic [2*WIDTH-1:0] mul_step(
    input logic [2*WIDTH-1:0] p,
    input logic [WIDTH-1:0]   a
  );
    logic [WIDTH:0] s;
    s = {1'b0, p[2*WIDTH-1:WIDTH]}
      + (p[0] ? {1'b0, a} : '0);
    return {s, p[WIDTH-1:1]};
  endfunction

  assign mul_first  = mul_step({{WIDTH{1'b0}}, operand_b},
                               operand_a);
  assign mul_step_p = mul_step(mul_p, mul_a);
`endif

  logic             ld;
  logic [WIDTH-1:0] ld_res;
  logic             ld_cout;
  logic             ld_ovf;

  always_comb begin
    state_nxt  = state;
    ld         = 1'b0;
    ld_res     = '0;
    ld_cout    = 1'b0;
    ld_ovf     = 1'b0;
    sh_val_nxt = sh_val;
    sh_rem_nxt = sh_rem;
    sh_op_nxt  = sh_op;
`ifdef ALU_MUL_EN
    mul_p_nxt   = mul_p;
    mul_a_nxt   = mul_a;
    mul_cnt_nxt = mul_cnt;
`endif
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          if (is_shift && (shamt > STEP)) begin
            state_nxt  = ST_SHIFT;
            sh_val_nxt = first_out;
            sh_rem_nxt = shamt - STEP;
            sh_op_nxt  = control;
          end
`ifdef ALU_MUL_EN
          else if (control == ALU_MUL) begin
            state_nxt   = ST_MUL;
            mul_p_nxt   = mul_first;
            mul_a_nxt   = operand_a;
            mul_cnt_nxt = SHW'(WIDTH - 2);
          end
`endif
          else if (is_shift) begin
            ld     = 1'b1;
            ld_res = first_out;
          end else begin
            ld      = 1'b1;
            ld_res  = core_res;
            ld_cout = core_cout;
            ld_ovf  = core_ovf;
          end
        end
      end
      ST_SHIFT: begin
        sh_val_nxt = sh_out;
        sh_rem_nxt = sh_rem - sh_amt;
        if (sh_rem <= STEP) begin
          state_nxt = ST_IDLE;
          ld        = 1'b1;
          ld_res    = sh_out;
        end
      end
`ifdef ALU_MUL_EN
      ST_MUL: begin
        mul_p_nxt   = mul_step_p;
        mul_cnt_nxt = mul_cnt - 1'b1;
        if (mul_cnt == '0) begin
          state_nxt = ST_IDLE;
          ld        = 1'b1;
          ld_res    = mul_step_p[WIDTH-1:0];
          ld_cout   = |mul_step_p[2*WIDTH-1:WIDTH];
        end
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_val <= '0;
      sh_rem <= '0;
      sh_op  <= '0;
`ifdef ALU_MUL_EN
      mul_p   <= '0;
      mul_a   <= '0;
      mul_cnt <= '0;
`endif
    end else begin
      sh_val <= sh_val_nxt;
      sh_rem <= sh_rem_nxt;
      sh_op  <= sh_op_nxt;
`ifdef ALU_MUL_EN
      mul_p   <= mul_p_nxt;
      mul_a   <= mul_a_nxt;
      mul_cnt <= mul_cnt_nxt;
`endif
    end
  end

  // a new load wins over release so back-to-back ops keep one per cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      carryout  <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else if (ld) begin
      out_valid <= 1'b1;
      result    <= ld_res;
      carryout  <= ld_cout;
      overflow  <= ld_ovf;
      zero      <= (ld_res == '0);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: scoreboard bench for alu_multicycle (WIDTH=32).
// Directed vectors; a monitor checks results, flags and latency.
module tb_alu_multicycle;
  import alu_pkg::*;

  parameter int SS = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic [3:0]  control = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        carryout;
  logic        overflow;
  logic        zero;

  alu_multicycle #(
    .WIDTH      (32),
    .SHIFT_STEP (SS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .control   (control),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carryout  (carryout),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          id;
    logic [31:0] res;
    logic        c;
    logic        o;
    logic        z;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s got=%0h want=%0h", name, act, req);
  endtask

  function automatic int slat(input int s);
    return (s == 0) ? 1 : (s + SS - 1) / SS;
  endfunction

  task automatic issue(input int id, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic c,
                       input logic o, input logic z,
                       input int lat, input bit track);
    exp_t e;
    int   n;
    control   = op;
    operand_a = a;
    operand_b = b;
    in_valid  = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      n_chk++;
      $display("FAIL v%0d_accept got=%0b want=1", id, in_ready);
      in_valid = 1'b0;
      return;
    end
    if (track) begin
      e.id  = id;
      e.res = r;
      e.c   = c;
      e.o   = o;
      e.z   = z;
      e.lat = lat;
      e.acc = cyc;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0 || out_valid) begin
      n_chk++;
      $display("FAIL drain got=%0d want=0 pending", sbq.size());
    end
  endtask

  // monitor: compares every presented cycle, pops on handshake
  bit seen = 0;
  int first_cyc = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
        seen = 0;
      end else if (out_valid) begin
        if (sbq.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_out got=%0h want=none",
                   result);
        end else begin
          e = sbq[0];
          if (!seen) begin
            seen = 1;
            first_cyc = cyc;
            check($sformatf("v%0d_lat", e.id),
                  64'(first_cyc - e.acc), 64'(e.lat));
          end
          check($sformatf("v%0d_res", e.id), 64'(result),
                64'(e.res));
          check($sformatf("v%0d_flags", e.id),
                {61'd0, carryout, overflow, zero},
                {61'd0, e.c, e.o, e.z});
          if (out_ready) begin
            void'(sbq.pop_front());
            seen = 0;
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_flags", {61'd0, carryout, overflow, zero}, 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    @(negedge clk);
    issue(1, ALU_ADD, 32'h7fffffff, 32'h7fffffff,
          32'hfffffffe, 0, 1, 0, 1, 1);
    @(negedge clk);
    issue(2, ALU_SUB, 32'd16, 32'd8, 32'd8, 1, 0, 0, 1, 1);
    @(negedge clk);
    issue(3, ALU_SUB, 32'd0, 32'd1, 32'hffffffff, 0, 0, 0, 1, 1);
    @(negedge clk);
    issue(4, ALU_ADD, 32'hffffffff, 32'd1, 32'd0, 1, 0, 1, 1, 1);
    @(negedge clk);
    issue(5, ALU_SUB, 32'h80000000, 32'd1, 32'h7fffffff,
          1, 1, 0, 1, 1);
    @(negedge clk);
    issue(6, ALU_AND, 32'hf0f0, 32'hff00, 32'hf000, 0, 0, 0, 1, 1);
    @(negedge clk);
    issue(7, ALU_XOR, 32'hff, 32'h0f, 32'hf0, 0, 0, 0, 1, 1);
    @(negedge clk);
    issue(8, ALU_OR, 32'hf0, 32'h0f, 32'hff, 0, 0, 0, 1, 1);
    @(negedge clk);
    issue(9, ALU_SLT, 32'h0000ffff, 32'hffffffff, 32'd0,
          0, 0, 1, 1, 1);
    @(negedge clk);
    issue(10, ALU_SLTU, 32'h0000ffff, 32'hffffffff, 32'd1,
          0, 0, 0, 1, 1);
    @(negedge clk);
    issue(11, ALU_SLT, 32'hffffffff, 32'd1, 32'd1, 0, 0, 0, 1, 1);
    @(negedge clk);
    issue(12, 4'd15, 32'd5, 32'd3, 32'd0, 0, 0, 1, 1, 1);

    @(negedge clk);
    issue(13, ALU_SRA, 32'h80000000, 32'd4, 32'hf8000000,
          0, 0, 0, slat(4), 1);
    check("sra_in_ready", 64'(in_ready), 64'(slat(4) <= 1));
    @(negedge clk);
    issue(14, ALU_SRL, 32'h0000ffff, 32'h24, 32'h00000fff,
          0, 0, 0, slat(4), 1);
    @(negedge clk);
    issue(15, ALU_SLL, 32'd1, 32'd0, 32'd1, 0, 0, 0, 1, 1);
    @(negedge clk);
    issue(16, ALU_SLL, 32'd1, 32'd31, 32'h80000000,
          0, 0, 0, slat(31), 1);
    @(negedge clk);
    issue(17, ALU_SRA, 32'h7ffffff0, 32'd4, 32'h07ffffff,
          0, 0, 0, slat(4), 1);

`ifdef ALU_MUL_EN
    @(negedge clk);
    issue(18, ALU_MUL, 32'h10000, 32'h10000, 32'd0,
          1, 0, 1, 32, 1);
    @(negedge clk);
    issue(19, ALU_MUL, 32'd3, 32'd5, 32'd15, 0, 0, 0, 32, 1);
    @(negedge clk);
    issue(20, ALU_MUL, 32'hffffffff, 32'd2, 32'hfffffffe,
          1, 0, 0, 32, 1);
`else
    @(negedge clk);
    issue(18, ALU_MUL, 32'h10000, 32'h10000, 32'd0,
          0, 0, 1, 1, 1);
`endif

    drain();
    @(negedge clk);
    out_ready = 1'b0;
    issue(21, ALU_ADD, 32'd1, 32'd1, 32'd2, 0, 0, 0, 1, 1);
    repeat (3) begin
      @(negedge clk);
      #1;
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    issue(22, ALU_AND, 32'hff, 32'h0f, 32'h0f, 0, 0, 0, 1, 1);

    drain();
    @(negedge clk);
    issue(30, ALU_SLL, 32'h0000ffff, 32'd16, 32'hffff0000,
          0, 0, 0, slat(16), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    repeat (30) @(negedge clk);
    issue(31, ALU_ADD, 32'd5, 32'd3, 32'd8, 0, 0, 0, 1, 1);

    drain();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
